fft_bfly_addr_gen: RTL and testbench
====================================

Name: fft_bfly_addr_gen

Overview:
- Read-side sequencer for the in-place radix-2 burst FFT engine, directly upstream of the butterfly.
- Walks all levels and butterflies of an N-point decimation-in-time FFT, with input already bit-reversed in the data RAM.
- Issues data-RAM A/B read addresses and twiddle-ROM addresses.
- Delays the control strobes (mult_en, fft_i_index, first_lev_s, level) so they arrive at the butterfly aligned with the RAM/ROM read data.

Parameters:
- ADDR_WIDTH, 10: log2 of maximum point count; RAM address width.
- RAM_RD_LAT, 2: read latency of data RAM and twiddle ROM, in cycles (≥1).
- BUTTERFLY_LAT, 1: butterfly latency; used only for level drain.
- WR_LAT, 1: writeback latency; used only for level drain.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start pulse; accepted only in IDLE
- fft_len_log2  in  4  log2(N); sampled on an accepted start
- stall  in  1  freezes issue of new reads
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final drain
- cfg_err  out  1  one-cycle pulse when a start carries an illegal length
- rd_en  out  1  data-RAM/ROM read strobe
- rd_addr_a  out  ADDR_WIDTH  A operand address
- rd_addr_b  out  ADDR_WIDTH  B operand address
- twiddle_addr  out  ADDR_WIDTH-1  twiddle ROM index (N_max/2 entries)
- mult_en  out  1  butterfly input valid (rd_en delayed RAM_RD_LAT)
- fft_i_index  out  ADDR_WIDTH  rd_addr_a delayed RAM_RD_LAT
- first_lev_s  out  1  level==0, delayed RAM_RD_LAT
- level_o  out  4  current level, delayed RAM_RD_LAT; used by writeback

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low. All outputs and all state reset to 0; FSM resets to IDLE.
- Let L = fft_len_log2 and N = 2^L.
  - Legal range: 1 ≤ L ≤ ADDR_WIDTH.
  - Start with an illegal L: cfg_err pulses, FSM stays in IDLE, busy stays low.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start with legal L. In that same cycle: latch L; clear level s and butterfly counter k; assert busy.
  - RUN, stall low: rd_en=1. Addresses are combinational from registered s and k:
    - j = k & (2^s − 1)
    - rd_addr_a = ((k >> s) << (s+1)) | j
    - rd_addr_b = rd_addr_a + 2^s
    - twiddle_addr = j << (ADDR_WIDTH−1−s)
  - RUN, stall high: rd_en=0, k and s hold. The delay line keeps shifting, inserting bubbles.
  - RUN, k increments each issued cycle. When k = N/2−1 is issued, go to DRAIN and load the drain counter with D = RAM_RD_LAT + BUTTERFLY_LAT + WR_LAT.
  - DRAIN: no reads. When the count expires:
    - if s = L−1, go to DONE;
    - otherwise s++, k = 0, go to RUN.
  - DONE: done=1 for one cycle, busy drops in the same cycle, FSM returns to IDLE.
- Delay line: a RAM_RD_LAT-deep shift register carries {rd_en, rd_addr_a, s==0, s}. Its outputs drive mult_en, fft_i_index, first_lev_s and level_o.
- Delay line contents while idle: it empties to zero naturally, and no stale strobe appears after done.
- start while busy is ignored; no cfg_err is raised.
- stall has no effect in IDLE, DRAIN or DONE.
- Reset mid-run: immediate return to IDLE. The delay line clears, so no mult_en leaks out.
- Total cycles from start to done with no stall: L·(N/2 + D) + 1.

Optional Feature:
- Macro: FFT_ADDR_GEN_IFFT_EN.
- With the macro defined:
  - adds input `ifft` (1 bit), sampled with L on an accepted start;
  - adds output `twiddle_conj`, which carries the sampled ifft through the delay line and is valid aligned with mult_en, so the twiddle imaginary part can be negated.
- Without the macro: neither port exists; forward transform only.

Decomposition:
- Shared package `fft_pkg` holds:
  - the FSM state encoding;
  - the width constant for fft_len_log2/level (4);
  - the drain-length function D(RAM_RD_LAT, BUTTERFLY_LAT, WR_LAT).
- One sub-module is natural: `fft_ctrl_delay`, a parameterised RAM_RD_LAT-deep register pipeline with async active-low reset. It is reused by the writeback side.

Test Plan:
- L=3, RAM_RD_LAT=2, no stall:
  - level 0 pairs (0,1)(2,3)(4,5)(6,7), twiddle 0;
  - level 1 pairs (0,2)(1,3)(4,6)(5,7), twiddle 0,256,0,256;
  - level 2 pairs (0,4)(1,5)(2,6)(3,7), twiddle 0,128,256,384;
  - mult_en trails rd_en by exactly 2 cycles; done pulses 3·(4+4)+1 = 25 cycles after start.
- L=1: exactly one read (0,1) with twiddle 0; first_lev_s=1 with mult_en; done after 1+4+1 cycles.
- L=3, stall held high for 3 cycles after the 2nd issued butterfly of level 1: address sequence unchanged, 3 bubbles on mult_en, done delayed by exactly 3 cycles.
- Illegal length:
  - start with L=0 → cfg_err=1 for one cycle, busy=0;
  - start with L=11 → same;
  - start pulsed while busy → ignored, sequence unaffected.
- Reset mid-run: rst_n low during level 1 of L=4 → all outputs 0 immediately; after release, a new start runs a full clean sequence.
- With FFT_ADDR_GEN_IFFT_EN defined: ifft=1 at start → twiddle_conj=1 on every mult_en cycle; ifft=0 → twiddle_conj=0 throughout.

Source files
------------

// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the radix-2 burst FFT engine control path:
//   sequencer FSM state encoding, width of the length/level fields, and the
//   per-level drain length used between butterfly levels.
// ----------------------------------------------------------------------------
package fft_pkg;

    // Width of fft_len_log2 and of the level counter.
    localparam int LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } fft_state_t;

    // Cycles to wait after the last read of a level so its results are
    // written back before the next level reads them.
    function automatic int drain_len(input int rd_lat, input int bf_lat, input int wr_lat);
        return rd_lat + bf_lat + wr_lat;
    endfunction

endpackage

// File: rtl/fft_ctrl_delay.sv
// ----------------------------------------------------------------------------
// fft_ctrl_delay
//   DEPTH-stage register pipeline for control strobes, used to align control
//   with RAM/ROM read data. Asynchronous active-low reset clears every stage.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   d      in   WIDTH  pipeline input
//   q      out  WIDTH  input delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module fft_ctrl_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/fft_bfly_addr_gen.sv
// ----------------------------------------------------------------------------
// fft_bfly_addr_gen
//   Read-side sequencer of the in-place radix-2 DIT burst FFT. Walks every
//   level s and butterfly k of an N = 2^L point transform (input already
//   bit-reversed in RAM), issues A/B data-RAM and twiddle-ROM addresses, and
//   delays the control strobes by RAM_RD_LAT so they meet the read data at
//   the butterfly. Each level is followed by a drain so writeback completes
//   before the next level reads.
//
// Optional macro FFT_ADDR_GEN_IFFT_EN adds the ifft input and the
// twiddle_conj output (ifft sampled at start, aligned with mult_en).
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            start pulse, accepted in IDLE only
//   fft_len_log2[4]  L, sampled on accepted start (legal 1..ADDR_WIDTH)
//   stall            holds issue of new reads while in RUN
//   ifft             (macro only) inverse transform select
//   busy             high while the transform is in progress
//   done             one-cycle pulse after the final drain
//   cfg_err          one-cycle pulse when start carries an illegal L
//   rd_en            read strobe
//   rd_addr_a/b      A/B operand addresses
//   twiddle_addr     twiddle ROM index (N_max/2 entries)
//   mult_en          rd_en delayed RAM_RD_LAT
//   fft_i_index      rd_addr_a delayed RAM_RD_LAT
//   first_lev_s      level==0 delayed RAM_RD_LAT
//   level_o          level delayed RAM_RD_LAT
//   twiddle_conj     (macro only) ifft delayed RAM_RD_LAT
// ----------------------------------------------------------------------------
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int RAM_RD_LAT    = 2,
    parameter int BUTTERFLY_LAT = 1,
    parameter int WR_LAT        = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      fft_len_log2,
    input  logic                  stall,
`ifdef FFT_ADDR_GEN_IFFT_EN
    input  logic                  ifft,
    output logic                  twiddle_conj,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [ADDR_WIDTH-2:0] twiddle_addr,
    output logic                  mult_en,
    output logic [ADDR_WIDTH-1:0] fft_i_index,
    output logic                  first_lev_s,
    output logic [LEN_W-1:0]      level_o
);

    localparam int DRAIN_CYC = drain_len(RAM_RD_LAT, BUTTERFLY_LAT, WR_LAT);
    localparam int CNT_W     = $clog2(DRAIN_CYC + 1);
    localparam int KW        = ADDR_WIDTH - 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(ADDR_WIDTH);
    localparam logic [LEN_W-1:0] TW_SH = LEN_W'(ADDR_WIDTH - 1);

    fft_state_t       state, state_n;
    logic [LEN_W-1:0] len, len_n;
    logic [LEN_W-1:0] lev, lev_n;
    logic [KW-1:0]    k, k_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             conj, conj_n;

    logic                  len_ok, last_k, last_lev;
    logic [ADDR_WIDTH-1:0] k_ext, span, j, addr_a, addr_b, half_m1;
    logic [ADDR_WIDTH-2:0] tw;

    // ------------------------------------------------------------------
    // Address arithmetic from registered level/butterfly counters
    // ------------------------------------------------------------------
    always_comb begin
        k_ext   = {1'b0, k};
        span    = ADDR_WIDTH'(1) << lev;
        j       = k_ext & (span - ADDR_WIDTH'(1));
        addr_a  = ((k_ext >> lev) << (lev + 4'd1)) | j;
        addr_b  = addr_a + span;
        tw      = j[ADDR_WIDTH-2:0] << (TW_SH - lev);
        half_m1 = (ADDR_WIDTH'(1) << (len - 4'd1)) - ADDR_WIDTH'(1);
        last_k  = (k_ext == half_m1);
        last_lev = (lev == len - 4'd1);
        len_ok  = (fft_len_log2 != '0) && (fft_len_log2 <= MAX_L);
    end

    // ------------------------------------------------------------------
    // FSM: state and counters register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            len   <= '0;
            lev   <= '0;
            k     <= '0;
            cnt   <= '0;
            conj  <= 1'b0;
        end else begin
            state <= state_n;
            len   <= len_n;
            lev   <= lev_n;
            k     <= k_n;
            cnt   <= cnt_n;
            conj  <= conj_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        len_n   = len;
        lev_n   = lev;
        k_n     = k;
        cnt_n   = cnt;
        conj_n  = conj;
        rd_en   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        cfg_err = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_n = ST_RUN;
                        len_n   = fft_len_log2;
                        lev_n   = '0;
                        k_n     = '0;
`ifdef FFT_ADDR_GEN_IFFT_EN
                        conj_n  = ifft;
`else
                        conj_n  = 1'b0;
`endif
                    end else begin
                        cfg_err = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (!stall) begin
                    rd_en = 1'b1;
                    if (last_k) begin
                        state_n = ST_DRAIN;
                        k_n     = '0;
                        cnt_n   = CNT_W'(DRAIN_CYC - 1);
                    end else begin
                        k_n = k + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    if (last_lev) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                        lev_n   = lev + 4'd1;
                        k_n     = '0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Addresses are forced to zero when no read is issued so idle/reset
    // outputs stay at zero and the delay line only ever carries real reads.
    assign rd_addr_a    = rd_en ? addr_a : '0;
    assign rd_addr_b    = rd_en ? addr_b : '0;
    assign twiddle_addr = rd_en ? tw     : '0;

    // ------------------------------------------------------------------
    // Control delay line aligned with RAM/ROM read latency
    // ------------------------------------------------------------------
`ifdef FFT_ADDR_GEN_IFFT_EN
    localparam int PIPE_W = ADDR_WIDTH + LEN_W + 3;
`else
    localparam int PIPE_W = ADDR_WIDTH + LEN_W + 2;
`endif

    logic [PIPE_W-1:0] pipe_in, pipe_out;

`ifdef FFT_ADDR_GEN_IFFT_EN
    assign pipe_in = rd_en ? {conj, 1'b1, addr_a, (lev == '0), lev} : '0;
    assign {twiddle_conj, mult_en, fft_i_index, first_lev_s, level_o} = pipe_out;
`else
    assign pipe_in = rd_en ? {1'b1, addr_a, (lev == '0), lev} : '0;
    assign {mult_en, fft_i_index, first_lev_s, level_o} = pipe_out;
`endif

    fft_ctrl_delay #(
        .WIDTH (PIPE_W),
        .DEPTH (RAM_RD_LAT)
    ) u_ctrl_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pipe_in),
        .q     (pipe_out)
    );

endmodule

// File: tb/tb_fft_bfly_addr_gen.sv
// ----------------------------------------------------------------------------
// tb_fft_bfly_addr_gen
//   Scoreboard bench for fft_bfly_addr_gen. Expected reads, butterfly strobes,
//   done and cfg_err events are generated from the FFT butterfly structure
//   (groups of span 2^s) and queued with their expected cycle; a monitor on
//   the falling edge pops and compares whenever the DUT presents one.
// ----------------------------------------------------------------------------
module tb_fft_bfly_addr_gen;

    localparam int AW   = 10;
    localparam int LAT  = 2;
    localparam int BL   = 1;
    localparam int WL   = 1;
    localparam int D    = LAT + BL + WL;
    localparam int NMAX = 1 << AW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic [3:0]    fft_len_log2 = '0;
    logic          busy, done, cfg_err, rd_en, mult_en, first_lev_s;
    logic [AW-1:0] rd_addr_a, rd_addr_b, fft_i_index;
    logic [AW-2:0] twiddle_addr;
    logic [3:0]    level_o;
`ifdef FFT_ADDR_GEN_IFFT_EN
    logic          ifft = 1'b0;
    logic          twiddle_conj;
`endif

    fft_bfly_addr_gen #(
        .ADDR_WIDTH    (AW),
        .RAM_RD_LAT    (LAT),
        .BUTTERFLY_LAT (BL),
        .WR_LAT        (WL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fft_len_log2 (fft_len_log2),
        .stall        (stall),
`ifdef FFT_ADDR_GEN_IFFT_EN
        .ifft         (ifft),
        .twiddle_conj (twiddle_conj),
`endif
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .rd_en        (rd_en),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .twiddle_addr (twiddle_addr),
        .mult_en      (mult_en),
        .fft_i_index  (fft_i_index),
        .first_lev_s  (first_lev_s),
        .level_o      (level_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int a; int b; int tw; int cyc; } rd_t;
    typedef struct { int idx; int first; int lvl; int conj; int cyc; } me_t;

    rd_t rd_q[$];
    me_t me_q[$];
    int  done_q[$];
    int  cfg_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: strobe high with nothing expected, required 0 (cycle %0d)", name, cyc);
    endfunction

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    rd_t re;
    me_t me;
    int  ev;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (rd_q.size() == 0) unexpected("rd_en");
                else begin
                    re = rd_q.pop_front();
                    chk("rd_addr_a", rd_addr_a, re.a);
                    chk("rd_addr_b", rd_addr_b, re.b);
                    chk("twiddle_addr", twiddle_addr, re.tw);
                    chk("rd_cycle", cyc, re.cyc);
                end
            end
            if (mult_en) begin
                if (me_q.size() == 0) unexpected("mult_en");
                else begin
                    me = me_q.pop_front();
                    chk("fft_i_index", fft_i_index, me.idx);
                    chk("first_lev_s", first_lev_s, me.first);
                    chk("level_o", level_o, me.lvl);
                    chk("mult_en_cycle", cyc, me.cyc);
`ifdef FFT_ADDR_GEN_IFFT_EN
                    chk("twiddle_conj", twiddle_conj, me.conj);
`endif
                end
            end
            if (done) begin
                if (done_q.size() == 0) unexpected("done");
                else begin
                    ev = done_q.pop_front();
                    chk("done_cycle", cyc, ev);
                    chk("busy_at_done", busy, 0);
                end
            end
            if (cfg_err) begin
                if (cfg_q.size() == 0) unexpected("cfg_err");
                else begin
                    ev = cfg_q.pop_front();
                    chk("cfg_err_cycle", cyc, ev);
                    chk("busy_at_cfg_err", busy, 0);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One transform. mode: 0 no stall, 1 random stall, 2 three-cycle stall
    // after the 2nd butterfly of level 1. extra_r: relative cycle of an
    // ignored start pulse (0 = none). rst_r: relative cycle of a reset
    // pulse that aborts the run (0 = none).
    // ------------------------------------------------------------------
    task automatic run_fft(input int L, input int mode, input int extra_r, input int rst_r, input bit ifv);
        int half, span, ngrp, r, r0, c0, done_r, rr, a;
        bit pat[$];
        @(posedge clk); #1;
        c0   = cyc;
        half = 1 << (L - 1);
        pat.push_back(1'b0);
        if (mode == 2) begin
            r0 = 1 + half + D + 2;
            while (pat.size() < r0 + 3) pat.push_back(pat.size() >= r0);
        end
        r = 0;
        for (int s = 0; s < L; s++) begin
            span = 1 << s;
            ngrp = (1 << L) / (2 * span);
            for (int g = 0; g < ngrp; g++) begin
                for (int jj = 0; jj < span; jj++) begin
                    do begin
                        r++;
                        while (pat.size() <= r) pat.push_back(mode == 1 && $urandom_range(0, 3) == 0);
                    end while (pat[r]);
                    a = g * 2 * span + jj;
                    rd_q.push_back('{a: a, b: a + span, tw: jj * (NMAX / 2) / span, cyc: c0 + r});
                    me_q.push_back('{idx: a, first: int'(s == 0), lvl: s, conj: int'(ifv), cyc: c0 + r + LAT});
                end
            end
            r += D;
        end
        done_r = r + 1;
        done_q.push_back(c0 + done_r);
        while (pat.size() <= done_r + LAT + 3) pat.push_back(mode == 1 && $urandom_range(0, 3) == 0);

        start        = 1'b1;
        fft_len_log2 = 4'(L);
`ifdef FFT_ADDR_GEN_IFFT_EN
        ifft         = ifv;
`endif
        for (int step = 1; step <= done_r + LAT + 3; step++) begin
            @(posedge clk); #1;
            rr    = cyc - c0;
            start = (rr == extra_r);
            if (rr == extra_r) fft_len_log2 = 4'($urandom_range(0, 15));
            stall = pat[rr];
            if (rr == 1) chk("busy_running", busy, 1);
            if (rr == done_r + 1) chk("busy_after_done", busy, 0);
            if (rr == rst_r) begin
                rst_n = 1'b0;
                #1;
                chk("rst_rd_en", rd_en, 0);
                chk("rst_mult_en", mult_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_rd_addr_a", rd_addr_a, 0);
                chk("rst_rd_addr_b", rd_addr_b, 0);
                chk("rst_twiddle_addr", twiddle_addr, 0);
                chk("rst_fft_i_index", fft_i_index, 0);
                chk("rst_first_lev_s", first_lev_s, 0);
                chk("rst_level_o", level_o, 0);
                rd_q.delete();
                me_q.delete();
                done_q.delete();
                stall = 1'b0;
                start = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                repeat (LAT + 3) @(posedge clk);
                return;
            end
        end
        stall = 1'b0;
        chk("pending_reads", rd_q.size(), 0);
        chk("pending_mult_en", me_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
    endtask

    task automatic cfg_test(input int L);
        @(posedge clk); #1;
        cfg_q.push_back(cyc);
        start        = 1'b1;
        fft_len_log2 = 4'(L);
        @(posedge clk); #1;
        start = 1'b0;
        chk("cfg_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("cfg_pending", cfg_q.size(), 0);
        chk("cfg_rd_en", rd_en, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_mult_en", mult_en, 0);
        chk("reset_rd_addr_b", rd_addr_b, 0);
        chk("reset_level_o", level_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_fft(3, 0, 0, 0, 1'b0);
        run_fft(1, 0, 0, 0, 1'b1);
        run_fft(3, 2, 0, 0, 1'b0);
        cfg_test(0);
        cfg_test(11);
        cfg_test(15);
        run_fft(5, 0, 7, 0, 1'b1);
        run_fft(4, 0, 0, 16, 1'b0);
        run_fft(4, 0, 0, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_fft($urandom_range(1, 7), 1, 0, 0, 1'($urandom_range(0, 1)));
        end
        run_fft(10, 0, 0, 0, 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
